// File: rtl/alu_req_scheduler.sv
// Two-port round-robin front end for one shared combinational ALU: registers the granted
// command onto the ALU inputs, waits SETTLE_CYCLES, then returns the result tagged with the port id.
module alu_req_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPRN_WIDTH    = 6,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [OPRN_WIDTH-1:0] req0_oprn,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [OPRN_WIDTH-1:0] req1_oprn,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [OPRN_WIDTH-1:0] alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_id,
    output logic                  rsp_err
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
    logic [OPRN_WIDTH-1:0] alu_oprn_q, alu_oprn_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  grant0, grant1;
    logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
    logic [OPRN_WIDTH-1:0] sel_oprn;
    logic                  sel_legal;

    always_comb begin
        // rr_q names the port that wins when both requesters are valid
        grant1     = req1_valid & (~req0_valid | rr_q);
        grant0     = req0_valid & ~grant1;
        req0_ready = (state_q == ST_IDLE) & grant0;
        req1_ready = (state_q == ST_IDLE) & grant1;

        sel_op1   = grant1 ? req1_op1  : req0_op1;
        sel_op2   = grant1 ? req1_op2  : req0_op2;
        sel_oprn  = grant1 ? req1_oprn : req0_oprn;
        sel_legal = (sel_oprn >= OPRN_WIDTH'(1)) && (sel_oprn <= OPRN_WIDTH'(9));

        state_d      = state_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_oprn_d   = alu_oprn_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    rsp_id_d = grant1;
                    if (sel_legal) begin
                        alu_op1_d  = sel_op1;
                        alu_op2_d  = sel_op2;
                        alu_oprn_d = sel_oprn;
                        cnt_d      = CNT_W'(1);
                        state_d    = ST_EXEC;
                    end else begin
                        // ALU inputs stay on the last legal command so it sees no toggles
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == SETTLE_LAST) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rr_d    = ~rsp_id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            cnt_q        <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_oprn_q   <= '0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_oprn_q   <= alu_oprn_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_oprn   = alu_oprn_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: a behavioural ALU closes the loop, directed scenarios plus a
// randomized run against a transaction-level model. Second instance uses a 3-cycle settle.
module tb_alu_req_scheduler;

    localparam int DW  = 32;
    localparam int OW  = 6;
    localparam int S_A = 1;
    localparam int S_B = 3;

    logic          clk;
    logic          rst, b_rst;
    logic          r0_valid, r0_ready, r1_valid, r1_ready;
    logic [DW-1:0] r0_op1, r0_op2, r1_op1, r1_op2;
    logic [OW-1:0] r0_oprn, r1_oprn;
    logic [DW-1:0] alu_op1, alu_op2, alu_result, rsp_result;
    logic [OW-1:0] alu_oprn;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;

    logic          b_r0_valid, b_r0_ready, b_r1_valid, b_r1_ready;
    logic [DW-1:0] b_r0_op1, b_r0_op2, b_r1_op1, b_r1_op2;
    logic [OW-1:0] b_r0_oprn, b_r1_oprn;
    logic [DW-1:0] b_alu_op1, b_alu_op2, b_alu_result, b_rsp_result;
    logic [OW-1:0] b_alu_oprn;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_err;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        case (op)
            6'h01:   return a + b;
            6'h02:   return a - b;
            6'h03:   return a * b;
            6'h04:   return a >> b;
            6'h05:   return a << b;
            6'h06:   return a & b;
            6'h07:   return a | b;
            6'h08:   return ~(a | b);
            6'h09:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic bit legal_fn(input logic [OW-1:0] op);
        return (op >= 6'h01) && (op <= 6'h09);
    endfunction

    assign alu_result   = alu_fn(alu_op1, alu_op2, alu_oprn);
    assign b_alu_result = alu_fn(b_alu_op1, b_alu_op2, b_alu_oprn);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_req_scheduler #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .SETTLE_CYCLES(S_A)) dut (
        .CLK(clk), .RST(rst),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_op1(r0_op1), .req0_op2(r0_op2),
        .req0_oprn(r0_oprn),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_op1(r1_op1), .req1_op2(r1_op2),
        .req1_oprn(r1_oprn),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    alu_req_scheduler #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .SETTLE_CYCLES(S_B)) dut_b (
        .CLK(clk), .RST(b_rst),
        .req0_valid(b_r0_valid), .req0_ready(b_r0_ready), .req0_op1(b_r0_op1),
        .req0_op2(b_r0_op2), .req0_oprn(b_r0_oprn),
        .req1_valid(b_r1_valid), .req1_ready(b_r1_ready), .req1_op1(b_r1_op1),
        .req1_op2(b_r1_op2), .req1_oprn(b_r1_oprn),
        .alu_op1(b_alu_op1), .alu_op2(b_alu_op2), .alu_oprn(b_alu_oprn),
        .alu_result(b_alu_result),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
        .rsp_id(b_rsp_id), .rsp_err(b_rsp_err)
    );

    // Inputs change on the falling edge; outputs are observed 1 time unit later.
    task automatic wait_ready(input int port, output int n);
        n = 0;
        while (((port == 0) ? r0_ready : r1_ready) !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic send(input int port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OW-1:0] op, output int n);
        @(negedge clk);
        if (port == 0) begin
            r0_valid = 1'b1; r0_op1 = a; r0_op2 = b; r0_oprn = op;
        end else begin
            r1_valid = 1'b1; r1_op1 = a; r1_op2 = b; r1_oprn = op;
        end
        #1;
        wait_ready(port, n);
    endtask

    task automatic wait_rsp(input bit drop0, input bit drop1, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                if (drop0) r0_valid = 1'b0;
                if (drop1) r1_valid = 1'b0;
            end
            #1;
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 50);
    endtask

    task automatic settle();
        @(negedge clk);
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        r0_valid = 0; r0_op1 = '0; r0_op2 = '0; r0_oprn = '0;
        r1_valid = 0; r1_op1 = '0; r1_op2 = '0; r1_oprn = '0;
        rsp_ready = 1'b0;
        b_r0_valid = 0; b_r0_op1 = '0; b_r0_op2 = '0; b_r0_oprn = '0;
        b_r1_valid = 0; b_r1_op1 = '0; b_r1_op2 = '0; b_r1_oprn = '0;
        b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0d want=0", rsp_valid); end
        total++; if (rsp_result !== '0) begin bad++; $display("FAIL reset_rsp_result got=%0d want=0", rsp_result); end
        total++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_id_err got=%0d/%0d want=0/0", rsp_id, rsp_err); end
        total++; if (alu_op1 !== '0 || alu_op2 !== '0 || alu_oprn !== '0) begin bad++; $display("FAIL reset_alu got=%0d/%0d/%0d want=0/0/0", alu_op1, alu_op2, alu_oprn); end
        total++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0d/%0d want=0/0", r0_ready, r1_ready); end
        total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_b_rsp_valid got=%0d want=0", b_rsp_valid); end
        @(negedge clk);
        rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_tie();
        int lat, n;
        @(negedge clk);
        rsp_ready = 1'b1;
        r0_valid = 1'b1; r0_op1 = 32'd5; r0_op2 = 32'd10; r0_oprn = 6'h03;
        r1_valid = 1'b1; r1_op1 = 32'd4; r1_op2 = 32'd1;  r1_oprn = 6'h04;
        #1;
        total++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin bad++; $display("FAIL tie_first_grant got=%0d/%0d want=1/0", r0_ready, r1_ready); end
        wait_rsp(1'b1, 1'b0, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL tie_lat0 got=%0d want=2", lat); end
        total++; if (rsp_result !== 32'd50) begin bad++; $display("FAIL tie_result0 got=%0d want=50", rsp_result); end
        total++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL tie_id_err0 got=%0d/%0d want=0/0", rsp_id, rsp_err); end
        total++; if (r1_ready !== 1'b0) begin bad++; $display("FAIL tie_no_accept_in_handshake got=%0d want=0", r1_ready); end
        wait_ready(1, n);
        total++; if (n != 1) begin bad++; $display("FAIL tie_second_grant_delay got=%0d want=1", n); end
        wait_rsp(1'b0, 1'b1, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL tie_lat1 got=%0d want=2", lat); end
        total++; if (rsp_result !== 32'd2) begin bad++; $display("FAIL tie_result1 got=%0d want=2", rsp_result); end
        total++; if (rsp_id !== 1'b1) begin bad++; $display("FAIL tie_id1 got=%0d want=1", rsp_id); end
        settle();
    endtask

    task automatic test_single();
        int lat, n;
        send(0, 32'd15, 32'd3, 6'h01, n);
        total++; if (n != 0) begin bad++; $display("FAIL single_ready_wait got=%0d want=0", n); end
        wait_rsp(1'b1, 1'b0, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL single_lat got=%0d want=2", lat); end
        total++; if (rsp_result !== 32'd18) begin bad++; $display("FAIL single_result got=%0d want=18", rsp_result); end
        total++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL single_id_err got=%0d/%0d want=0/0", rsp_id, rsp_err); end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_drop got=%0d want=0", rsp_valid); end
        settle();
    endtask

    task automatic test_alternate();
        int grants[$];
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        r0_valid = 1'b1; r0_op1 = 32'd1; r0_op2 = 32'd1; r0_oprn = 6'h01;
        r1_valid = 1'b1; r1_op1 = 32'd2; r1_op2 = 32'd2; r1_oprn = 6'h01;
        #1;
        for (int c = 0; c < 20; c++) begin
            total++;
            if (r0_ready === 1'b1 && r1_ready === 1'b1) begin
                bad++; $display("FAIL alt_both_ready cycle=%0d got=1 want=0", c);
            end
            if (r0_ready === 1'b1) grants.push_back(0);
            else if (r1_ready === 1'b1) grants.push_back(1);
            @(negedge clk);
            #1;
        end
        total++; if (grants.size() < 4) begin bad++; $display("FAIL alt_grant_count got=%0d want>=4", grants.size()); end
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            total++;
            if (grants[k] != (k % 2)) begin bad++; $display("FAIL alt_order idx=%0d got=%0d want=%0d", k, grants[k], k % 2); end
        end
        settle();
    endtask

    task automatic test_backpressure();
        int lat, n;
        rsp_ready = 1'b0;
        send(0, 32'd12, 32'd3, 6'h07, n);
        total++; if (n != 0) begin bad++; $display("FAIL bp_ready_wait got=%0d want=0", n); end
        wait_rsp(1'b1, 1'b0, lat);
        total++; if (lat != 2 || rsp_result !== 32'd15) begin bad++; $display("FAIL bp_first got=lat%0d/res%0d want=lat2/res15", lat, rsp_result); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                r1_valid = 1'b1; r1_op1 = 32'd1; r1_op2 = 32'd1; r1_oprn = 6'h01;
            end
            #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold c=%0d got=%0d want=1", c, rsp_valid); end
            total++; if (rsp_result !== 32'd15) begin bad++; $display("FAIL bp_result_hold c=%0d got=%0d want=15", c, rsp_result); end
            total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL bp_id_hold c=%0d got=%0d want=0", c, rsp_id); end
            total++; if (r1_ready !== 1'b0) begin bad++; $display("FAIL bp_no_accept c=%0d got=%0d want=0", c, r1_ready); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b1 || r1_ready !== 1'b0) begin bad++; $display("FAIL bp_handshake got=v%0d/r%0d want=v1/r0", rsp_valid, r1_ready); end
        wait_ready(1, n);
        total++; if (n != 1) begin bad++; $display("FAIL bp_next_grant got=%0d want=1", n); end
        wait_rsp(1'b0, 1'b1, lat);
        total++; if (lat != 2 || rsp_result !== 32'd2 || rsp_id !== 1'b1) begin bad++; $display("FAIL bp_second got=lat%0d/res%0d/id%0d want=lat2/res2/id1", lat, rsp_result, rsp_id); end
        settle();
    endtask

    task automatic test_illegal();
        int            t_port[4] = '{1, 0, 0, 1};
        logic [DW-1:0] t_a[4]    = '{32'd7, 32'd8, 32'd3, 32'd6};
        logic [DW-1:0] t_b[4]    = '{32'd9, 32'd2, 32'd5, 32'd4};
        logic [OW-1:0] t_op[4]   = '{6'h0F, 6'h00, 6'h09, 6'h0A};
        logic [DW-1:0] la = 32'd1, lb = 32'd1, e_res;
        logic [OW-1:0] lo = 6'h01;
        bit            lg;
        int            lat, n;
        for (int i = 0; i < 4; i++) begin
            lg    = legal_fn(t_op[i]);
            e_res = lg ? alu_fn(t_a[i], t_b[i], t_op[i]) : '0;
            if (lg) begin la = t_a[i]; lb = t_b[i]; lo = t_op[i]; end
            send(t_port[i], t_a[i], t_b[i], t_op[i], n);
            total++; if (n != 0) begin bad++; $display("FAIL ill_ready_wait i=%0d got=%0d want=0", i, n); end
            wait_rsp(t_port[i] == 0, t_port[i] == 1, lat);
            total++; if (lat != (lg ? 2 : 1)) begin bad++; $display("FAIL ill_lat i=%0d got=%0d want=%0d", i, lat, lg ? 2 : 1); end
            total++; if (rsp_err !== !lg) begin bad++; $display("FAIL ill_err i=%0d got=%0d want=%0d", i, rsp_err, !lg); end
            total++; if (rsp_result !== e_res) begin bad++; $display("FAIL ill_result i=%0d got=%0d want=%0d", i, rsp_result, e_res); end
            total++; if (rsp_id !== t_port[i][0]) begin bad++; $display("FAIL ill_id i=%0d got=%0d want=%0d", i, rsp_id, t_port[i]); end
            total++; if (alu_op1 !== la || alu_op2 !== lb || alu_oprn !== lo) begin bad++; $display("FAIL ill_alu_hold i=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, alu_op1, alu_op2, alu_oprn, la, lb, lo); end
        end
        settle();
    endtask

    task automatic test_random();
        bit            busy = 0, e_id = 0, e_err = 0, pref = 0;
        bit            ev, eg0, eg1;
        int            e_start = 0;
        logic [DW-1:0] e_res = '0, a, b;
        logic [OW-1:0] op;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r0_valid = ($urandom_range(0, 2) != 0);
            r0_op1 = $urandom(); r0_op2 = $urandom(); r0_oprn = OW'($urandom_range(0, 11));
            r1_valid = ($urandom_range(0, 2) != 0);
            r1_op1 = $urandom(); r1_op2 = $urandom(); r1_oprn = OW'($urandom_range(0, 11));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            ev  = busy && (i >= e_start);
            eg0 = !busy && r0_valid && (!r1_valid || !pref);
            eg1 = !busy && r1_valid && (!r0_valid || pref);
            total++; if (r0_ready !== eg0) begin bad++; $display("FAIL rnd_ready0 cyc=%0d got=%0d want=%0d", i, r0_ready, eg0); end
            total++; if (r1_ready !== eg1) begin bad++; $display("FAIL rnd_ready1 cyc=%0d got=%0d want=%0d", i, r1_ready, eg1); end
            total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%0d want=%0d", i, rsp_valid, ev); end
            if (ev) begin
                total++;
                if (rsp_result !== e_res || rsp_id !== e_id || rsp_err !== e_err) begin
                    bad++;
                    $display("FAIL rnd_rsp cyc=%0d got=%0h/id%0d/err%0d want=%0h/id%0d/err%0d", i, rsp_result, rsp_id, rsp_err, e_res, e_id, e_err);
                end
            end
            if (ev && rsp_ready) begin
                busy = 0;
                pref = !e_id;
            end else if (eg0 || eg1) begin
                busy = 1;
                e_id = eg1;
                a    = eg1 ? r1_op1  : r0_op1;
                b    = eg1 ? r1_op2  : r0_op2;
                op   = eg1 ? r1_oprn : r0_oprn;
                if (legal_fn(op)) begin
                    e_res = alu_fn(a, b, op); e_err = 0; e_start = i + 1 + S_A;
                end else begin
                    e_res = '0; e_err = 1; e_start = i + 1;
                end
            end
        end
        settle();
    endtask

    task automatic test_reset_exec();
        int lat;
        @(negedge clk);
        b_rsp_ready = 1'b1;
        b_r0_valid = 1'b1; b_r0_op1 = 32'd15; b_r0_op2 = 32'd3; b_r0_oprn = 6'h01;
        #1;
        total++; if (b_r0_ready !== 1'b1) begin bad++; $display("FAIL rx_accept got=%0d want=1", b_r0_ready); end
        @(negedge clk); b_r0_valid = 1'b0; #1;
        @(negedge clk); #1;
        total++; if (b_rsp_valid !== 1'b0 || b_alu_op1 !== 32'd15) begin bad++; $display("FAIL rx_exec got=v%0d/op1=%0d want=v0/op1=15", b_rsp_valid, b_alu_op1); end
        // third settle cycle: the capture edge coincides with reset
        @(negedge clk); b_rst = 1'b1; #1;
        @(negedge clk); b_rst = 1'b0; #1;
        total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL rx_valid_cleared got=%0d want=0", b_rsp_valid); end
        total++; if (b_rsp_result !== '0 || b_rsp_err !== 1'b0 || b_rsp_id !== 1'b0) begin bad++; $display("FAIL rx_rsp_cleared got=%0d/%0d/%0d want=0/0/0", b_rsp_result, b_rsp_err, b_rsp_id); end
        total++; if (b_alu_op1 !== '0 || b_alu_op2 !== '0 || b_alu_oprn !== '0) begin bad++; $display("FAIL rx_alu_cleared got=%0d/%0d/%0d want=0/0/0", b_alu_op1, b_alu_op2, b_alu_oprn); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL rx_no_rsp c=%0d got=%0d want=0", c, b_rsp_valid); end
        end
        @(negedge clk);
        b_r1_valid = 1'b1; b_r1_op1 = 32'd5; b_r1_op2 = 32'd7; b_r1_oprn = 6'h01;
        #1;
        total++; if (b_r1_ready !== 1'b1) begin bad++; $display("FAIL rx_idle_accept got=%0d want=1", b_r1_ready); end
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) b_r1_valid = 1'b0;
            #1;
            lat++;
        end while (b_rsp_valid !== 1'b1 && lat < 50);
        total++; if (lat != S_B + 1) begin bad++; $display("FAIL rx_lat3 got=%0d want=%0d", lat, S_B + 1); end
        total++; if (b_rsp_result !== 32'd12 || b_rsp_id !== 1'b1 || b_rsp_err !== 1'b0) begin bad++; $display("FAIL rx_rsp got=%0d/id%0d/err%0d want=12/id1/err0", b_rsp_result, b_rsp_id, b_rsp_err); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_alternate();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
